pipe_chain: RTL and testbench

Parametrised N-stage in-order pipeline skeleton that generalises the hand-wired per-stage ready/flush network of the CPU top. Each stage holds a valid bit and a WIDTH-bit payload. Stages advance through a combinational backward ready chain and accept per-stage stall (busy) inputs. Any stage can flush all younger stages. Used as the stage-register and control backbone for the next core and for test harnesses of single stages.

---
 rtl/pipe_chain_if.sv | 29 ++
 rtl/pipe_chain.sv | 116 +++++++++++
 tb/tb_pipe_chain.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_chain_if.sv
// pipe_chain_if: producer/consumer handshake, per-stage control and observation bundle for pipe_chain.
// master = driver of the pipeline (producer, consumer, control), slave = the pipeline itself.
interface pipe_chain_if #(
  parameter int STAGES = 7,
  parameter int WIDTH  = 64
);
  logic                      in_valid;
  logic [WIDTH-1:0]          in_data;
  logic                      in_ready;
  logic [STAGES-1:0]         stage_busy;
  logic [STAGES-1:0]         flush_req;
  logic [STAGES-1:0]         stage_valid;
  logic [STAGES*WIDTH-1:0]   stage_data;
  logic                      out_valid;
  logic [WIDTH-1:0]          out_data;
  logic                      out_ready;
  logic [31:0]               retire_cnt;
  logic [31:0]               kill_cnt;

  modport master (
    output in_valid, in_data, stage_busy, flush_req, out_ready,
    input  in_ready, stage_valid, stage_data, out_valid, out_data, retire_cnt, kill_cnt
  );

  modport slave (
    input  in_valid, in_data, stage_busy, flush_req, out_ready,
    output in_ready, stage_valid, stage_data, out_valid, out_data, retire_cnt, kill_cnt
  );
endinterface

// File: rtl/pipe_chain.sv
// pipe_chain: N-stage in-order valid/payload pipeline with a combinational backward ready chain,
// per-stage stalls and flush of younger stages. Define PIPE_TRACE_EN to build retire/kill counters.
module pipe_chain #(
  parameter int STAGES = 7,
  parameter int WIDTH  = 64
) (
  input  logic        clk,
  input  logic        rst,
  pipe_chain_if.slave bus
);
  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [STAGES-1:0] fire;
  logic [STAGES-1:0] kill;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] valid_d;
  logic              rdy0;
  logic              any_flush;
  logic              accept;

  // Walk from the oldest stage down: r is rdy[i+1], k is "some flush_req above stage i".
  always_comb begin
    logic r;
    logic k;
    r    = bus.out_ready;
    k    = 1'b0;
    fire = '0;
    kill = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      fire[i] = valid_q[i] & ~bus.stage_busy[i] & r;
      r       = ~valid_q[i] | fire[i];
      kill[i] = k;
      k       = k | bus.flush_req[i];
    end
    rdy0      = r;
    any_flush = k;
  end

  assign accept = bus.in_valid & rdy0 & ~any_flush;

  // A killed upstream stage never hands its payload on, so flush dominates transfer.
  always_comb begin
    load    = '0;
    valid_d = '0;
    load[0] = accept;
    for (int i = 1; i < STAGES; i++) begin
      load[i] = fire[i-1] & ~kill[i-1];
    end
    for (int i = 0; i < STAGES; i++) begin
      valid_d[i] = ~kill[i] & (load[i] | (valid_q[i] & ~fire[i]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      if (load[0]) begin
        data_q[0] <= bus.in_data;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (load[i]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign bus.in_ready    = rdy0;
  assign bus.stage_valid = valid_q;
  assign bus.out_valid   = valid_q[STAGES-1];
  assign bus.out_data    = data_q[STAGES-1];

  always_comb begin
    bus.stage_data = '0;
    for (int i = 0; i < STAGES; i++) begin
      bus.stage_data[i*WIDTH +: WIDTH] = data_q[i];
    end
  end

`ifdef PIPE_TRACE_EN
  logic [31:0] retire_q;
  logic [31:0] kill_q;
  logic [31:0] kill_add;

  // Only stages that actually held an item count as killed; a dropped input does not.
  always_comb begin
    kill_add = '0;
    for (int i = 0; i < STAGES; i++) begin
      kill_add = kill_add + 32'(valid_q[i] & kill[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_q <= '0;
      kill_q   <= '0;
    end else begin
      if (valid_q[STAGES-1] & bus.out_ready) begin
        retire_q <= retire_q + 32'd1;
      end
      kill_q <= kill_q + kill_add;
    end
  end

  assign bus.retire_cnt = retire_q;
  assign bus.kill_cnt   = kill_q;
`else
  assign bus.retire_cnt = '0;
  assign bus.kill_cnt   = '0;
`endif
endmodule

// File: tb/tb_pipe_chain.sv
// tb_pipe_chain: table-driven check of pipe_chain (STAGES=4, WIDTH=8) with a payload scoreboard.
// Counter expectations follow PIPE_TRACE_EN.
module tb_pipe_chain;
  localparam int STAGES = 4;
  localparam int WIDTH  = 8;
`ifdef PIPE_TRACE_EN
  localparam bit TRACE = 1'b1;
`else
  localparam bit TRACE = 1'b0;
`endif

  typedef struct {
    logic        iv;
    logic [7:0]  d;
    logic [3:0]  busy;
    logic [3:0]  flush;
    logic        ordy;
    logic        exp_ir;
    logic [3:0]  exp_sv;
    logic [3:0]  dmask;
    logic [31:0] exp_sd;
    int          kill_n;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failures = 0;
  vec_t vecs[$];
  logic [7:0] sbq[$];

  pipe_chain_if #(.STAGES(STAGES), .WIDTH(WIDTH)) bus ();

  pipe_chain #(.STAGES(STAGES), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic iv, logic [7:0] d, logic [3:0] busy, logic [3:0] flush,
                              logic ordy, logic ir, logic [3:0] sv);
    vec_t v;
    v.iv = iv; v.d = d; v.busy = busy; v.flush = flush; v.ordy = ordy;
    v.exp_ir = ir; v.exp_sv = sv; v.dmask = 4'b0000; v.exp_sd = '0; v.kill_n = 0;
    return v;
  endfunction

  // Continuous pushes at cycles 0..n-1 from an empty pipe: stage i holds the item pushed at c-1-i.
  function automatic logic [3:0] streamSv(int c, int n);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) s[i] = (c - 1 - i >= 0) && (c - 1 - i < n);
    return s;
  endfunction

  task automatic addStream(int base, int n);
    for (int c = 0; c < n + 4; c++) begin
      vecs.push_back(mk(c < n, 8'(base + c), 4'b0000, 4'b0000, 1'b1, 1'b1, streamSv(c, n)));
    end
  endtask

  task automatic applyStimulus(vec_t v);
    @(negedge clk);
    bus.in_valid   = v.iv;
    bus.in_data    = v.d;
    bus.stage_busy = v.busy;
    bus.flush_req  = v.flush;
    bus.out_ready  = v.ordy;
    #1;
  endtask

  task automatic checkOutput(vec_t v, int idx);
    compare($sformatf("row%0d in_ready", idx), 32'(bus.in_ready), 32'(v.exp_ir));
    compare($sformatf("row%0d stage_valid", idx), 32'(bus.stage_valid), 32'(v.exp_sv));
    compare($sformatf("row%0d out_valid", idx), 32'(bus.out_valid), 32'(v.exp_sv[3]));
    for (int i = 0; i < STAGES; i++) begin
      if (v.dmask[i]) begin
        compare($sformatf("row%0d stage_data[%0d]", idx, i),
                32'(bus.stage_data[i*WIDTH +: WIDTH]), 32'(v.exp_sd[i*8 +: 8]));
      end
    end
    if (v.exp_sv[3]) begin
      if (sbq.size() == 0) begin
        tests++;
        failures++;
        $display("[TB] FAIL row%0d scoreboard: got out_valid with empty queue, expected no output", idx);
      end else begin
        compare($sformatf("row%0d out_data", idx), 32'(bus.out_data), 32'(sbq[0]));
        if (v.ordy && !v.busy[3]) void'(sbq.pop_front());
      end
    end
    if (v.iv && v.exp_ir && v.flush == 4'b0000) sbq.push_back(v.d);
    for (int n = 0; n < v.kill_n; n++) begin
      if (sbq.size() > 0) void'(sbq.pop_back());
    end
  endtask

  task automatic runTable();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end
    vecs.delete();
  endtask

  initial begin
    vec_t v;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.stage_busy = '0;
    bus.flush_req = '0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    compare("reset stage_valid", 32'(bus.stage_valid), 32'h0);
    compare("reset stage_data", 32'(bus.stage_data), 32'h0);
    compare("reset out_valid", 32'(bus.out_valid), 32'h0);
    compare("reset in_ready", 32'(bus.in_ready), 32'h1);
    compare("reset retire_cnt", bus.retire_cnt, 32'h0);
    compare("reset kill_cnt", bus.kill_cnt, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Streaming 0x01..0x08, then backpressure with 0x10..0x14.
    addStream(8'h01, 8);
    vecs.push_back(mk(1, 8'h10, 4'b0000, 4'b0000, 0, 1, 4'b0000));
    vecs.push_back(mk(1, 8'h11, 4'b0000, 4'b0000, 0, 1, 4'b0001));
    vecs.push_back(mk(1, 8'h12, 4'b0000, 4'b0000, 0, 1, 4'b0011));
    vecs.push_back(mk(1, 8'h13, 4'b0000, 4'b0000, 0, 1, 4'b0111));
    vecs.push_back(mk(1, 8'h14, 4'b0000, 4'b0000, 0, 0, 4'b1111));
    vecs.push_back(mk(1, 8'h14, 4'b0000, 4'b0000, 1, 1, 4'b1111));
    vecs.push_back(mk(0, 8'h00, 4'b0000, 4'b0000, 1, 1, 4'b1111));
    vecs.push_back(mk(0, 8'h00, 4'b0000, 4'b0000, 1, 1, 4'b1110));
    vecs.push_back(mk(0, 8'h00, 4'b0000, 4'b0000, 1, 1, 4'b1100));
    vecs.push_back(mk(0, 8'h00, 4'b0000, 4'b0000, 1, 1, 4'b1000));
    runTable();

    // Bubble collapse behind a busy oldest stage.
    vecs.push_back(mk(1, 8'hA1, 4'b0000, 4'b0000, 0, 1, 4'b0000));
    vecs.push_back(mk(1, 8'hA0, 4'b0000, 4'b0000, 0, 1, 4'b0001));
    v = mk(0, 8'h00, 4'b1000, 4'b0000, 0, 1, 4'b0011);
    v.dmask = 4'b0011; v.exp_sd = {16'h0000, 8'hA1, 8'hA0};
    vecs.push_back(v);
    vecs.push_back(mk(0, 8'h00, 4'b1000, 4'b0000, 0, 1, 4'b0110));
    v = mk(0, 8'h00, 4'b1000, 4'b0000, 0, 1, 4'b1100);
    v.dmask = 4'b1100; v.exp_sd = {8'hA1, 8'hA0, 16'h0000};
    vecs.push_back(v);
    v = mk(1, 8'hB0, 4'b1000, 4'b0000, 0, 1, 4'b1100);
    v.dmask = 4'b1100; v.exp_sd = {8'hA1, 8'hA0, 16'h0000};
    vecs.push_back(v);
    vecs.push_back(mk(1, 8'hB1, 4'b1000, 4'b0000, 0, 1, 4'b1101));
    vecs.push_back(mk(1, 8'hB2, 4'b1000, 4'b0000, 0, 0, 4'b1111));
    vecs.push_back(mk(0, 8'h00, 4'b0000, 4'b0000, 1, 1, 4'b1111));
    vecs.push_back(mk(0, 8'h00, 4'b0000, 4'b0000, 1, 1, 4'b1110));
    vecs.push_back(mk(0, 8'h00, 4'b0000, 4'b0000, 1, 1, 4'b1100));
    vecs.push_back(mk(0, 8'h00, 4'b0000, 4'b0000, 1, 1, 4'b1000));
    runTable();

    // Flush at stage 2 with the oldest retiring and a new input offered.
    vecs.push_back(mk(1, 8'h33, 4'b0000, 4'b0000, 0, 1, 4'b0000));
    vecs.push_back(mk(1, 8'h32, 4'b0000, 4'b0000, 0, 1, 4'b0001));
    vecs.push_back(mk(1, 8'h31, 4'b0000, 4'b0000, 0, 1, 4'b0011));
    vecs.push_back(mk(1, 8'h30, 4'b0000, 4'b0000, 0, 1, 4'b0111));
    v = mk(1, 8'h34, 4'b0000, 4'b0100, 1, 1, 4'b1111);
    v.dmask = 4'b1111; v.exp_sd = {8'h33, 8'h32, 8'h31, 8'h30}; v.kill_n = 2;
    vecs.push_back(v);
    v = mk(0, 8'h00, 4'b0000, 4'b0000, 1, 1, 4'b1000);
    v.dmask = 4'b1000; v.exp_sd = {8'h32, 24'h0};
    vecs.push_back(v);
    runTable();
    compare("flush kill_cnt", bus.kill_cnt, TRACE ? 32'd2 : 32'd0);
    compare("flush retire_cnt", bus.retire_cnt, TRACE ? 32'd19 : 32'd0);

    // Asynchronous reset with three valid stages.
    vecs.push_back(mk(1, 8'h40, 4'b0000, 4'b0000, 0, 1, 4'b0000));
    vecs.push_back(mk(1, 8'h41, 4'b0000, 4'b0000, 0, 1, 4'b0001));
    vecs.push_back(mk(1, 8'h42, 4'b0000, 4'b0000, 0, 1, 4'b0011));
    runTable();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    compare("pre-reset stage_valid", 32'(bus.stage_valid), 32'h7);
    #1;
    rst = 1'b1;
    #1;
    compare("mid reset stage_valid", 32'(bus.stage_valid), 32'h0);
    compare("mid reset out_valid", 32'(bus.out_valid), 32'h0);
    compare("mid reset stage_data", 32'(bus.stage_data), 32'h0);
    compare("mid reset retire_cnt", bus.retire_cnt, 32'h0);
    compare("mid reset kill_cnt", bus.kill_cnt, 32'h0);
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    compare("post reset in_ready", 32'(bus.in_ready), 32'h1);

    // Ten retires, then a flush at the top stage killing three valid stages.
    addStream(8'h50, 10);
    vecs.push_back(mk(1, 8'h60, 4'b0000, 4'b0000, 0, 1, 4'b0000));
    vecs.push_back(mk(1, 8'h61, 4'b0000, 4'b0000, 0, 1, 4'b0001));
    vecs.push_back(mk(1, 8'h62, 4'b0000, 4'b0000, 0, 1, 4'b0011));
    v = mk(0, 8'h00, 4'b0000, 4'b1000, 0, 1, 4'b0111);
    v.kill_n = 3;
    vecs.push_back(v);
    vecs.push_back(mk(0, 8'h00, 4'b0000, 4'b0000, 0, 1, 4'b0000));
    runTable();
    compare("trace retire_cnt", bus.retire_cnt, TRACE ? 32'd10 : 32'd0);
    compare("trace kill_cnt", bus.kill_cnt, TRACE ? 32'd3 : 32'd0);
    compare("scoreboard drained", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
